deskew_c: RTL and testbench
===========================

DESKEW_C -- requirements
Module: deskew_c

Interface
REQ-001 Parameter BITS_C, default 16, is the signed result element width.
REQ-002 Parameter DIM, default 8, is the number of lanes and the number of rows per tile.
REQ-003 Parameter FDEPTH, default 4, is the number of output row FIFO entries; it shall be a power of two and at least 2.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port en, input, 1 bit: advances the skew pipeline by one step.
REQ-007 Port in_valid, input, 1 bit: qualifies the lane-0 element as the start of a row.
REQ-008 Port Cin, input, DIM x BITS_C signed: skewed lanes; lane j carries element C[r][j] DIM-1-... at en-step r+j.
REQ-009 Port Cout, output, DIM x BITS_C signed: the de-skewed row at the FIFO head.
REQ-010 Port Crow, output, $clog2(DIM) bits: the row index of Cout.
REQ-011 Port out_valid, output, 1 bit: high while the FIFO holds at least one row.
REQ-012 Port out_ready, input, 1 bit: consumer accept; a pop occurs when out_valid and out_ready are both high.
REQ-013 Port overflow, output, 1 bit: sticky flag set when a row is dropped.
REQ-014 Port tile_done, output, 1 bit: one-cycle pulse on the pop of row DIM-1.

Function
REQ-015 Lane j shall be delayed by DIM-1-j en-steps through a shift register; lane DIM-1 shall pass with zero extra delay.
REQ-016 The in_valid tag shall travel through a DIM-1 stage tag chain that advances only when en=1.
REQ-017 Cycles with en=0 shall hold all lane and tag stages unchanged.
REQ-018 A row is complete on the en=1 edge at which its tag exits stage DIM-1, i.e. en-step r+DIM-1 for a row whose in_valid was at step r.
REQ-019 A completed row shall be pushed into the FIFO on that same edge, together with a write-row counter value that wraps modulo DIM.
REQ-020 out_valid shall rise in the cycle after the push edge (push-to-visible latency of 1 cycle).
REQ-021 On push when the FIFO is full with no pop in the same cycle, the row shall be dropped, overflow shall be set, and the write-row counter shall still increment.
REQ-022 On push when the FIFO is full with a pop in the same cycle, the push shall be accepted, occupancy shall be unchanged, and overflow shall not be set.
REQ-023 A pop on an empty FIFO shall be impossible, since out_valid=0 blocks it.
REQ-024 Simultaneous push and pop on a non-full FIFO shall leave occupancy unchanged.
REQ-025 Cout and Crow shall hold stable while out_valid=1 and out_ready=0.
REQ-026 tile_done shall assert for exactly one cycle when a pop occurs with Crow = DIM-1.
REQ-027 The input side has no backpressure; data loss is possible only as described in REQ-021.

Reset
REQ-028 On rst_n=0, all lane stages, tag stages, FIFO pointers and counters, and the write-row counter shall clear to 0, asynchronously.
REQ-029 On reset, out_valid, overflow, and tile_done shall be 0, and Cout and Crow shall be 0.
REQ-030 A reset asserted mid-tile shall discard all partial rows and queued rows; no row shall emerge after release without a new in_valid.

Structure
REQ-031 BITS_C, DIM, ROWBITS=$clog2(DIM), FDEPTH, and the type c_row_t (an array of DIM signed BITS_C elements) shall live in the shared package systolic_pkg.
REQ-032 The FIFO shall be the sub-module row_fifo, with push/pop/full/empty ports and a payload of c_row_t plus ROWBITS.

Verification
REQ-033 Stream an 8-row tile where C[r][j]=16*r+j, with en held at 1 and out_ready=1 -> rows 0..7 appear in order, each row's first visibility exactly DIM cycles after the row's in_valid, and tile_done pulses on row 7.
REQ-034 Same tile with en toggled 1,0,1,0 -> output rows are identical to the previous scenario, with each row's first visibility delayed by 7 en-steps plus 1 cycle after the row's in_valid.
REQ-035 Hold out_ready=0 for a full tile -> 4 rows are queued, rows 4..7 are dropped, overflow=1, Cout stays at row 0, and the subsequent pops yield Crow 0,1,2,3.
REQ-036 Hold out_ready=0 until the FIFO is full, then raise out_ready on the same cycle as the next push -> no drop, overflow=0, and occupancy stays at 4.
REQ-037 Assert rst_n=0 after 3 rows of a tile -> out_valid=0 immediately, and after release a fresh tile yields Crow starting at 0 with no stale data.
REQ-038 Stream lanes at the extremes of -32768 and 32767 -> Cout reproduces both values bit-exact with sign preserved.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared sizing and row types for the systolic result path.
package systolic_pkg;
  localparam int BITS_C  = 16;
  localparam int DIM     = 8;
  localparam int ROWBITS = $clog2(DIM);
  localparam int FDEPTH  = 4;

  typedef logic [DIM-1:0][BITS_C-1:0] c_row_t;
endpackage

// File: rtl/row_fifo.sv
// Row FIFO holding de-skewed rows with their row index; a full push
// is accepted only if a pop frees a slot on the same edge.
module row_fifo
  import systolic_pkg::*;
#(
  parameter int DIM    = systolic_pkg::DIM,
  parameter int BITS_C = systolic_pkg::BITS_C,
  parameter int FDEPTH = systolic_pkg::FDEPTH,
  parameter int RB     = systolic_pkg::ROWBITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DIM-1:0][BITS_C-1:0]   wr_data,
  input  logic [RB-1:0]                wr_idx,
  output logic                         full,
  output logic                         empty,
  output logic [DIM-1:0][BITS_C-1:0]   rd_data,
  output logic [RB-1:0]                rd_idx
);
  localparam int AW = $clog2(FDEPTH);

  logic [FDEPTH-1:0][DIM-1:0][BITS_C-1:0] mem_d;
  logic [FDEPTH-1:0][RB-1:0]              mem_i;
  logic [AW-1:0]                          wr_ptr, rd_ptr;
  logic [AW:0]                            cnt;
  logic                                   do_push, do_pop;

  assign full    = (cnt == (AW+1)'(FDEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_d  <= '0;
      mem_i  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr] <= wr_data;
        mem_i[wr_ptr] <= wr_idx;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rd_data = mem_d[rd_ptr];
  assign rd_idx  = mem_i[rd_ptr];
endmodule

// File: rtl/skew_lane.sv
// One lane of the de-skew delay: DEPTH en-gated register stages.
module skew_lane #(
  parameter int W     = 16,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [DEPTH-1:0][W-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];
endmodule

// File: rtl/deskew_c.sv
// Re-aligns skewed result lanes into whole rows and queues them for a
// ready/valid consumer; rows arriving into a full queue are dropped.
module deskew_c
  import systolic_pkg::*;
#(
  parameter int BITS_C = systolic_pkg::BITS_C,
  parameter int DIM    = systolic_pkg::DIM,
  parameter int FDEPTH = systolic_pkg::FDEPTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              in_valid,
  input  logic signed [DIM-1:0][BITS_C-1:0] Cin,
  output logic signed [DIM-1:0][BITS_C-1:0] Cout,
  output logic [$clog2(DIM)-1:0]            Crow,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              overflow,
  output logic                              tile_done
);
  localparam int RB = $clog2(DIM);

  logic [DIM-1:0][BITS_C-1:0] aligned;
  logic [DIM-1:1]             vld_pipe;
  logic [RB-1:0]              wr_row;
  logic                       push, pop, full, empty;

  // Lane j waits DIM-1-j steps so every lane lines up with the last one.
  for (genvar j = 0; j < DIM-1; j++) begin : g_lane
    skew_lane #(.W(BITS_C), .DEPTH(DIM-1-j)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .d    (Cin[j]),
      .q    (aligned[j])
    );
  end
  assign aligned[DIM-1] = Cin[DIM-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (en) begin
      vld_pipe[1] <= in_valid;
      for (int k = 2; k < DIM; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  assign push = en & vld_pipe[DIM-1];
  assign pop  = out_valid & out_ready;

  // Row index advances even for dropped rows so indices stay tile-relative.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_row   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_row <= (wr_row == RB'(DIM-1)) ? '0 : wr_row + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  row_fifo #(.DIM(DIM), .BITS_C(BITS_C), .FDEPTH(FDEPTH), .RB(RB)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .wr_data(aligned),
    .wr_idx (wr_row),
    .full   (full),
    .empty  (empty),
    .rd_data(Cout),
    .rd_idx (Crow)
  );

  assign out_valid = ~empty;
  assign tile_done = pop && (Crow == RB'(DIM-1));
endmodule

// File: tb/tb_deskew_c.sv
// Scoreboard bench for deskew_c: rows expected at drive time, checked at pop.
module tb_deskew_c;
  import systolic_pkg::*;
  localparam int W = BITS_C;
  localparam int N = DIM;

  logic                     clk = 1'b0;
  logic                     rst_n, en, in_valid, out_ready;
  logic signed [N-1:0][W-1:0] Cin, Cout;
  logic [ROWBITS-1:0]       Crow;
  logic                     out_valid, overflow, tile_done;

  always #5 clk = ~clk;

  deskew_c #(.BITS_C(W), .DIM(N), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .Cin(Cin),
    .Cout(Cout), .Crow(Crow), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .tile_done(tile_done)
  );

  typedef struct {
    c_row_t d;
    int     row;
    int     vis;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0, cyc = 0, row_ctr = 0, head_since = 0;
  bit   prev_v = 0, prev_pop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [W-1:0] elem(input int kind, input int r, input int j);
    if (kind == 0) return W'(16*r + j);
    return ((r + j) % 2 == 1) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      prev_v   = 0;
      prev_pop = 0;
    end else begin
      if (out_valid && (!prev_v || prev_pop)) head_since = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_pop", 1, 0);
        else begin
          e = sb.pop_front();
          chk("crow", Crow, e.row);
          chk("cout", Cout, e.d);
          chk("tile_done", tile_done, (e.row == N-1));
          if (e.vis >= 0) chk("first_vis", head_since, e.vis);
        end
      end else begin
        if (tile_done) chk("tile_done_idle", tile_done, 0);
        if (out_valid && sb.size() > 0) begin
          chk("hold_crow", Crow, sb[0].row);
          chk("hold_cout", Cout, sb[0].d);
        end
      end
      prev_v   = out_valid;
      prev_pop = out_valid && out_ready;
    end
  end

  // per: cycles per en-step; keep: rows expected to survive; rdy_at: step
  // at which out_ready is raised (-1 = untouched); kind: data pattern.
  task automatic drive_tile(input int per, input int keep, input int rdy_at,
                            input int nsteps, input int kind);
    for (int s = 0; s < nsteps; s++) begin
      @(posedge clk); #1;
      if (s == rdy_at) out_ready = 1'b1;
      en       = 1'b1;
      in_valid = (s < N);
      for (int j = 0; j < N; j++) begin
        int r;
        r = s - j;
        Cin[j] = (r >= 0 && r < N) ? elem(kind, r, j) : '0;
      end
      if (s < N) begin
        if (s < keep) begin
          exp_t e;
          for (int j = 0; j < N; j++) e.d[j] = elem(kind, s, j);
          e.row = row_ctr;
          e.vis = (rdy_at < 0 && out_ready) ? cyc + (N-1)*per + 1 : -1;
          sb.push_back(e);
        end
        row_ctr = (row_ctr + 1) % N;
      end
      for (int k = 1; k < per; k++) begin
        @(posedge clk); #1;
        en       = 1'b0;
        in_valid = 1'($urandom_range(0, 1));
        for (int j = 0; j < N; j++) Cin[j] = W'($urandom);
      end
    end
    @(posedge clk); #1;
    en       = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    chk(tag, sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; en = 0; in_valid = 0; out_ready = 0; Cin = '0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", tile_done, 0);
    chk("rst_cout", Cout, 0);
    chk("rst_crow", Crow, 0);
    @(negedge clk) rst_n = 1;

    // streaming tile, en every cycle
    out_ready = 1;
    drive_tile(1, N, -1, 2*N-1, 0);
    wait_drain("drain_stream", 60);

    // en toggling 1,0,1,0
    drive_tile(2, N, -1, 2*N-1, 0);
    wait_drain("drain_toggle", 80);

    // fill queue, then release ready in the cycle of the next push
    out_ready = 0;
    drive_tile(1, N, 11, 2*N-1, 0);
    wait_drain("drain_fullpop", 60);
    chk("ovf_fullpop", overflow, 0);

    // full tile with no consumer: rows 4..7 dropped
    out_ready = 0;
    drive_tile(1, FDEPTH, -1, 2*N-1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_set", overflow, 1);
    chk("full_valid", out_valid, 1);
    out_ready = 1;
    wait_drain("drain_drop", 60);
    chk("empty_after_drop", out_valid, 0);

    // reset mid-tile with rows queued and rows in flight
    out_ready = 0;
    drive_tile(1, 0, -1, 10, 0);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_crow", Crow, 0);
    chk("mid_rst_cout", Cout, 0);
    @(negedge clk) rst_n = 1;
    row_ctr = 0;
    sb.delete();
    en = 1; in_valid = 0; Cin = '1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) chk("stale_row", out_valid, 0);
    end
    chk("no_stale", out_valid, 0);
    en = 0;
    out_ready = 1;
    drive_tile(1, N, -1, 2*N-1, 0);
    wait_drain("drain_after_rst", 60);

    // signed extremes
    drive_tile(1, N, -1, 2*N-1, 1);
    wait_drain("drain_extreme", 60);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
